water_heater_controller: RTL and testbench
==========================================

Name: water_heater_controller

Overview:
- Downstream consumer of the temperature selection stage. It latches the selected wash temperature, drives the heater until the water reaches that target, then regulates with hysteresis.
- It signals "temperature reached" to the wash-cycle sequencer.
- It flags a fault if heating does not complete within a time budget.

Parameters:
- TEMP_W, 6, width of all temperature values (degC, unsigned).
- HYST, 2, hysteresis band in degC below target before reheating in HOLD.
- TIMEOUT_CYCLES, 3000, max clk cycles allowed in HEAT before fault (300 s at 100 ms clk).
- CNT_W, 12, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin heating; sampled only in IDLE.
- abort  input  1  level or pulse; returns block to IDLE from any state.
- selected_temperature  input  TEMP_W  target from temperature selection stage; latched on accepted start.
- measured_temp  input  TEMP_W  water temperature sample from sensor interface.
- measured_valid  input  1  qualifies measured_temp for one cycle.
- heater_on  output  1  heater relay enable.
- temp_reached  output  1  target reached; held until IDLE.
- heat_fault  output  1  heating timeout fault; sticky until abort or reset.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous) forces the following, and all latched state clears:
  - state=IDLE
  - heater_on=0, temp_reached=0, heat_fault=0, busy=0
  - target=0, timeout counter=0
- States: IDLE, HEAT, HOLD, FAULT. Encoding is 2-bit binary.
- IDLE:
  - On start=1 with abort=0: latch target<=selected_temperature and clear the counter.
  - If target==0 (cold wash), go to HOLD with temp_reached=1 and heater_on=0.
  - Otherwise go to HEAT with heater_on=1 and busy=1, effective the cycle after start.
  - start with abort in the same cycle: abort wins and the block stays in IDLE.
- HEAT:
  - heater_on=1; the counter increments every cycle.
  - measured_valid=1 with measured_temp>=target: go to HOLD. Next cycle heater_on=0 and temp_reached=1.
  - Counter reaching TIMEOUT_CYCLES-1 without success: go to FAULT. Next cycle heater_on=0 and heat_fault=1.
  - If the success sample arrives in the same cycle as the timeout, success wins.
  - measured_valid=0: no action other than counting.
- HOLD:
  - temp_reached=1 throughout.
  - Low threshold = target-HYST, saturating at 0.
  - measured_valid with measured_temp < low threshold: heater_on<=1.
  - measured_valid with measured_temp>=target: heater_on<=0.
  - Otherwise heater_on holds its value.
  - The timeout does not run in HOLD.
  - With target==0 the heater never turns on.
- FAULT:
  - heater_on=0, heat_fault=1, busy=1.
  - start is ignored; only abort or reset exits.
- abort=1 in HEAT, HOLD or FAULT: next cycle the state is IDLE and all outputs are 0.
- start while busy is ignored. selected_temperature changes while busy are ignored; the latched target is used.
- Comparisons are unsigned TEMP_W-bit; there is no arithmetic overflow path.

Decomposition:
- Shared package washer_pkg holds:
  - TEMP_W
  - the heater state enum (IDLE/HEAT/HOLD/FAULT)
  - default HYST and TIMEOUT_CYCLES constants, which the wash-mode and temperature stages also reference
- One sub-module: heat_timeout_counter. Ports: clk, reset, clear, enable, expired. Parameterised by TIMEOUT_CYCLES and CNT_W.
- Hysteresis compare and FSM stay in the top module.

Test Plan:
- Normal heat (TIMEOUT_CYCLES=20): target 40, start pulse; measured 30, 35, then 40 valid.
  - heater_on=1 one cycle after start.
  - On the 40 sample: HOLD, heater_on=0, temp_reached=1, heat_fault=0.
- Hysteresis in HOLD, target 40, HYST 2:
  - Sample 39 -> heater stays 0.
  - Sample 37 -> heater_on=1.
  - Sample 39 -> heater stays 1.
  - Sample 40 -> heater_on=0; temp_reached stays 1 throughout.
- Timeout (TIMEOUT_CYCLES=20): target 60, samples stuck at 25.
  - After 20 cycles in HEAT: heater_on=0, heat_fault=1.
  - start is ignored.
  - abort -> IDLE, all outputs 0.
- Cold wash: selected_temperature=0, start -> next cycle HOLD, temp_reached=1, heater_on=0; heater never asserts for any sample.
- Start/abort collision and mid-operation reset:
  - start and abort in the same cycle -> busy stays 0.
  - Reset asserted asynchronously mid-HEAT -> heater_on=0 immediately, without waiting for a clock edge.
  - After reset release, a new start with target 20 latches 20, not the old target.
- Busy lockout: during HEAT with target 40, change selected_temperature to 60 and pulse start -> the block still transitions to HOLD on a measured 40.

Source files
------------

// File: rtl/washer_pkg.sv
// Shared washer definitions: temperature width, heater FSM states and default
// regulation constants used by the wash-mode, temperature and heater stages.
package washer_pkg;

    localparam int TEMP_W                 = 6;
    localparam int DEFAULT_HYST           = 2;
    localparam int DEFAULT_TIMEOUT_CYCLES = 3000;
    localparam int DEFAULT_CNT_W          = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HEAT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } heater_state_t;

    // Subtraction clamped at zero so a small target never wraps to a high threshold.
    function automatic logic [TEMP_W-1:0] sat_sub(
        input logic [TEMP_W-1:0] a,
        input logic [TEMP_W-1:0] b
    );
        logic [TEMP_W-1:0] res;
        if (a > b) begin
            res = a - b;
        end else begin
            res = {TEMP_W{1'b0}};
        end
        return res;
    endfunction

endpackage

// File: rtl/heat_timeout_counter.sv
// Heating time budget counter: counts enabled cycles and flags the last allowed one.
module heat_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 3000,
    parameter int CNT_W          = 12
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_r;

    // Cycle counter; saturates at LAST so it can never wrap back to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable && (count_r != LAST)) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == LAST);

endmodule

// File: rtl/water_heater_controller.sv
// Water heater controller: heats to the latched wash temperature, then regulates
// with hysteresis; reports temperature reached and heating timeout fault.
module water_heater_controller
    import washer_pkg::*;
#(
    parameter int HYST           = DEFAULT_HYST,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [TEMP_W-1:0] selected_temperature,
    input  logic [TEMP_W-1:0] measured_temp,
    input  logic              measured_valid,
    output logic              heater_on,
    output logic              temp_reached,
    output logic              heat_fault,
    output logic              busy
);

    localparam logic [TEMP_W-1:0] HYST_V = TEMP_W'(HYST);

    heater_state_t     state_r, state_s;
    logic [TEMP_W-1:0] target_r, target_s;
    logic              heater_on_r, heater_on_s;
    logic              temp_reached_r, temp_reached_s;
    logic              heat_fault_r, heat_fault_s;
    logic              busy_r, busy_s;
    logic              cnt_clear_s, cnt_enable_s, expired_s;
    logic [TEMP_W-1:0] low_thresh_s;

    heat_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear_s),
        .enable  (cnt_enable_s),
        .expired (expired_s)
    );

    assign low_thresh_s = sat_sub(target_r, HYST_V);

    // Next-state and next-output decode; abort overrides every state.
    always_comb begin
        state_s        = state_r;
        target_s       = target_r;
        heater_on_s    = heater_on_r;
        temp_reached_s = temp_reached_r;
        heat_fault_s   = heat_fault_r;
        busy_s         = busy_r;
        cnt_clear_s    = 1'b0;
        cnt_enable_s   = 1'b0;

        if (abort) begin
            state_s        = ST_IDLE;
            heater_on_s    = 1'b0;
            temp_reached_s = 1'b0;
            heat_fault_s   = 1'b0;
            busy_s         = 1'b0;
            cnt_clear_s    = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    heater_on_s    = 1'b0;
                    temp_reached_s = 1'b0;
                    heat_fault_s   = 1'b0;
                    busy_s         = 1'b0;
                    if (start) begin
                        target_s    = selected_temperature;
                        cnt_clear_s = 1'b1;
                        busy_s      = 1'b1;
                        if (selected_temperature == {TEMP_W{1'b0}}) begin
                            state_s        = ST_HOLD;
                            temp_reached_s = 1'b1;
                        end else begin
                            state_s     = ST_HEAT;
                            heater_on_s = 1'b1;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_HEAT: begin
                    cnt_enable_s = 1'b1;
                    busy_s       = 1'b1;
                    // A success sample on the timeout cycle still counts as success.
                    if (measured_valid && (measured_temp >= target_r)) begin
                        state_s        = ST_HOLD;
                        heater_on_s    = 1'b0;
                        temp_reached_s = 1'b1;
                    end else if (expired_s) begin
                        state_s      = ST_FAULT;
                        heater_on_s  = 1'b0;
                        heat_fault_s = 1'b1;
                    end else begin
                        heater_on_s = 1'b1;
                    end
                end
                ST_HOLD: begin
                    temp_reached_s = 1'b1;
                    busy_s         = 1'b1;
                    if (measured_valid && (measured_temp < low_thresh_s)) begin
                        heater_on_s = 1'b1;
                    end else if (measured_valid && (measured_temp >= target_r)) begin
                        heater_on_s = 1'b0;
                    end else begin
                        heater_on_s = heater_on_r;
                    end
                end
                ST_FAULT: begin
                    heater_on_s  = 1'b0;
                    heat_fault_s = 1'b1;
                    busy_s       = 1'b1;
                end
                default: begin
                    state_s        = ST_IDLE;
                    heater_on_s    = 1'b0;
                    temp_reached_s = 1'b0;
                    heat_fault_s   = 1'b0;
                    busy_s         = 1'b0;
                end
            endcase
        end
    end

    // State, latched target and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            target_r       <= {TEMP_W{1'b0}};
            heater_on_r    <= 1'b0;
            temp_reached_r <= 1'b0;
            heat_fault_r   <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_s;
            target_r       <= target_s;
            heater_on_r    <= heater_on_s;
            temp_reached_r <= temp_reached_s;
            heat_fault_r   <= heat_fault_s;
            busy_r         <= busy_s;
        end
    end

    assign heater_on    = heater_on_r;
    assign temp_reached = temp_reached_r;
    assign heat_fault   = heat_fault_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_water_heater_controller.sv
// Directed self-checking bench for water_heater_controller with a 20-cycle timeout.
module tb_water_heater_controller;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [5:0] selected_temperature;
    logic [5:0] measured_temp;
    logic       measured_valid;
    logic       heater_on;
    logic       temp_reached;
    logic       heat_fault;
    logic       busy;

    int errors = 0;
    int checks = 0;

    water_heater_controller #(
        .HYST           (2),
        .TIMEOUT_CYCLES (20),
        .CNT_W          (12)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .start                (start),
        .abort                (abort),
        .selected_temperature (selected_temperature),
        .measured_temp        (measured_temp),
        .measured_valid       (measured_valid),
        .heater_on            (heater_on),
        .temp_reached         (temp_reached),
        .heat_fault           (heat_fault),
        .busy                 (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs packed as {heater_on, temp_reached, heat_fault, busy}
    task automatic check_outs(input string tag, input logic [3:0] exp);
        check_eq(tag, {28'd0, heater_on, temp_reached, heat_fault, busy}, {28'd0, exp});
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic sample(input logic [5:0] t);
        measured_temp  = t;
        measured_valid = 1'b1;
        tick();
        measured_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        selected_temperature = 6'd0;
        measured_temp = 6'd0;
        measured_valid = 1'b0;
        tick();
        tick();
        check_outs("reset_outputs", 4'b0000);
        reset = 1'b1;
        tick();
        check_outs("idle_after_reset", 4'b0000);

        // Normal heat to 40
        selected_temperature = 6'd40;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_outs("heat_entry", 4'b1001);
        sample(6'd30);
        check_outs("heat_30", 4'b1001);
        sample(6'd35);
        check_outs("heat_35", 4'b1001);
        sample(6'd40);
        check_outs("reach_40", 4'b0101);

        // Hysteresis: low threshold 38
        sample(6'd39);
        check_outs("hold_39_off", 4'b0101);
        sample(6'd37);
        check_outs("hold_37_on", 4'b1101);
        sample(6'd39);
        check_outs("hold_39_stays_on", 4'b1101);
        sample(6'd38);
        check_outs("hold_38_stays_on", 4'b1101);
        sample(6'd40);
        check_outs("hold_40_off", 4'b0101);
        tick();
        check_outs("hold_no_sample", 4'b0101);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_outs("abort_from_hold", 4'b0000);

        // Timeout: target 60, stuck at 25
        selected_temperature = 6'd60;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_outs("timeout_heat_entry", 4'b1001);
        measured_temp = 6'd25;
        measured_valid = 1'b1;
        for (int i = 0; i < 19; i++) tick();
        check_outs("timeout_not_yet", 4'b1001);
        tick();
        check_outs("timeout_fault", 4'b0011);
        measured_valid = 1'b0;
        selected_temperature = 6'd30;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_outs("fault_ignores_start", 4'b0011);
        tick();
        check_outs("fault_sticky", 4'b0011);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_outs("abort_from_fault", 4'b0000);

        // Cold wash
        selected_temperature = 6'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_outs("cold_hold", 4'b0101);
        sample(6'd0);
        check_outs("cold_sample_0", 4'b0101);
        sample(6'd63);
        check_outs("cold_sample_63", 4'b0101);
        sample(6'd10);
        check_outs("cold_sample_10", 4'b0101);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_outs("abort_from_cold", 4'b0000);

        // Start/abort collision
        selected_temperature = 6'd40;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_outs("collision_idle", 4'b0000);
        tick();
        check_outs("collision_still_idle", 4'b0000);

        // Asynchronous reset mid-HEAT
        start = 1'b1;
        tick();
        start = 1'b0;
        check_outs("pre_reset_heat", 4'b1001);
        #2;
        reset = 1'b0;
        #1;
        check_outs("async_reset_immediate", 4'b0000);
        tick();
        reset = 1'b1;
        tick();
        check_outs("post_reset_idle", 4'b0000);

        // New target 20 must be used, not the old 40
        selected_temperature = 6'd20;
        start = 1'b1;
        tick();
        start = 1'b0;
        selected_temperature = 6'd40;
        check_outs("new_target_heat", 4'b1001);
        sample(6'd19);
        check_outs("new_target_19", 4'b1001);
        sample(6'd20);
        check_outs("new_target_20", 4'b0101);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_outs("abort_from_new", 4'b0000);

        // Busy lockout: restart with 60 ignored
        selected_temperature = 6'd40;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_outs("lockout_heat", 4'b1001);
        selected_temperature = 6'd60;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_outs("lockout_restart_ignored", 4'b1001);
        sample(6'd40);
        check_outs("lockout_reach_40", 4'b0101);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_outs("final_idle", 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
